idex_skid_stage: RTL and testbench
==================================

# idex_skid_stage

Parametrised ID/EX pipeline stage with a valid/ready handshake and a two-entry skid buffer. It sits between decode and execute in the pipelined datapath. It captures the same control and operand bundle as the fixed ID/EX register, and adds four things: stall back-pressure without combinational ready paths, synchronous flush for branch/jump squash, forced-NOP control on bubbles, and a saturating stall counter for performance monitoring.

## Interface
Parameters:
- DATA_W, 32, width of PC+4, register operands and sign-extended immediate
- REG_W, 5, register-specifier width
- ALUOP_W, 3, ALUOp field width; EX bundle width is ALUOP_W+2
- WB_W, 2, write-back control width
- MEM_W, 3, memory control width
- JADDR_W, 26, jump target field width
- CNT_W, 16, stall counter width

Ports:
- clkIDEX  in  1  stage clock, rising edge
- rstIDEX_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode presents a valid bundle
- in_ready  out  1  stage can accept; registered, equals !skid_valid
- flush  in  1  synchronous squash of all held entries
- WB1 / M1 / EX  in  WB_W / MEM_W / ALUOP_W+2  control fields; EX = {ALUSrc, ALUOp, RegDst}
- fIFIDa4, fBR1, fBR2, fSE  in  DATA_W each  PC+4, rs value, rt value, sign-extended immediate
- fIns1, fIns2  in  REG_W each  rt and rd specifiers
- jump_in  in  1; insad_in  in  JADDR_W  jump flag and target field
- out_valid  out  1  execute-side bundle valid
- out_ready  in  1  execute accepts
- Wb1, Mem1, RegDst, ALUOp, ALUSrc, tAdd, tALU, tMux32, tACsl, tMux5_1, tMux5_2, jump_out, insad_out  out  matching widths  registered bundle
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid & !out_ready

## Operation
- Storage: main entry (drives outputs) and skid entry; each has a valid bit.
- States: EMPTY (main invalid), BUSY (main valid, skid invalid), FULL (both valid).
- Accept: in_valid & in_ready. Issue: out_valid & out_ready. out_valid = main_valid.
- EMPTY + accept → BUSY; input goes to main.
- BUSY + accept + issue → BUSY; input replaces main.
- BUSY + accept, no issue → FULL; input goes to skid.
- BUSY + issue, no accept → EMPTY.
- FULL + issue → BUSY; skid moves to main. in_ready is 0 in FULL, so no accept occurs.
- FULL, no issue → hold.
- Flush (highest priority): main_valid and skid_valid are cleared next cycle. Any bundle accepted in the flush cycle is discarded. The state goes to EMPTY.
- Bubble rule: while main_valid = 0, Wb1, Mem1 and jump_out are driven 0. Data fields hold their last value.
- EX decode: RegDst = EX[0], ALUOp = EX[ALUOP_W:1], ALUSrc = EX[ALUOP_W+1].
- stall_cnt increments on each cycle with out_valid & !out_ready. It saturates at 2^CNT_W-1. It is not cleared by flush.

## Timing
- Reset (async assert, sync release) sets: both valids 0, in_ready 1, out_valid 0, all bundle outputs 0, stall_cnt 0. Reset mid-transfer drops both entries.
- Latency: 1 cycle from accept into an EMPTY stage to out_valid.
- Throughput: 1 bundle/cycle while out_ready stays high.
- in_ready is registered with no combinational path from out_ready. After out_ready rises in FULL, in_ready returns to 1 one cycle later.
- Ordering is strictly FIFO, with no loss or duplication without a flush.
- flush together with out_ready: the issue in that cycle counts as consumed. Nothing is valid afterward.
- flush in EMPTY has no effect except discarding a simultaneous accept.

## Test plan
- Reset: hold rstIDEX_n=0 with random inputs → out_valid=0, in_ready=1, Wb1=0, tAdd=0, stall_cnt=0. Release, then apply in_valid with fIFIDa4=0x00000404 → next cycle out_valid=1, tAdd=0x00000404.
- Streaming: out_ready=1, send 8 bundles on consecutive cycles with fBR1=0..7 → tALU=0..7 on 8 consecutive cycles, in_ready stays 1, stall_cnt=0.
- Back-pressure: send A, B, C with out_ready=0 → A held on outputs, B in skid, in_ready=0 after B. Raise out_ready → A, B, C emerge in order, and stall_cnt equals the number of stalled cycles.
- EX decode: EX=5'b10111 → RegDst=1, ALUOp=3'b011, ALUSrc=1.
- Flush: in FULL, pulse flush while in_valid=1 → next cycle out_valid=0, Wb1=0, Mem1=0, jump_out=0, in_ready=1, and no flushed bundle ever appears.
- Saturation: CNT_W=4, hold out_valid with out_ready=0 for 20 cycles → stall_cnt=15 and stays there.

Source files
------------

// File: rtl/idex_skid_stage.sv
// ID/EX pipeline stage with valid/ready handshake and a two-entry skid buffer.
// The main entry drives the execute-side outputs and the skid entry absorbs the
// one extra bundle that can arrive while in_ready is still high. Flush squashes
// both entries. Bubbles force WB/MEM/jump control to zero. A saturating counter
// counts stalled cycles.
module idex_skid_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned ALUOP_W = 3,
  parameter int unsigned WB_W    = 2,
  parameter int unsigned MEM_W   = 3,
  parameter int unsigned JADDR_W = 26,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 clkIDEX,
  input  logic                 rstIDEX_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  input  logic [WB_W-1:0]      WB1,
  input  logic [MEM_W-1:0]     M1,
  input  logic [ALUOP_W+1:0]   EX,
  input  logic [DATA_W-1:0]    fIFIDa4,
  input  logic [DATA_W-1:0]    fBR1,
  input  logic [DATA_W-1:0]    fBR2,
  input  logic [DATA_W-1:0]    fSE,
  input  logic [REG_W-1:0]     fIns1,
  input  logic [REG_W-1:0]     fIns2,
  input  logic                 jump_in,
  input  logic [JADDR_W-1:0]   insad_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WB_W-1:0]      Wb1,
  output logic [MEM_W-1:0]     Mem1,
  output logic                 RegDst,
  output logic [ALUOP_W-1:0]   ALUOp,
  output logic                 ALUSrc,
  output logic [DATA_W-1:0]    tAdd,
  output logic [DATA_W-1:0]    tALU,
  output logic [DATA_W-1:0]    tMux32,
  output logic [DATA_W-1:0]    tACsl,
  output logic [REG_W-1:0]     tMux5_1,
  output logic [REG_W-1:0]     tMux5_2,
  output logic                 jump_out,
  output logic [JADDR_W-1:0]   insad_out,
  output logic [CNT_W-1:0]     stall_cnt
);

  typedef struct packed {
    logic [WB_W-1:0]    wb;
    logic [MEM_W-1:0]   mem;
    logic [ALUOP_W+1:0] ex;
    logic [DATA_W-1:0]  a4;
    logic [DATA_W-1:0]  br1;
    logic [DATA_W-1:0]  br2;
    logic [DATA_W-1:0]  se;
    logic [REG_W-1:0]   ins1;
    logic [REG_W-1:0]   ins2;
    logic               jump;
    logic [JADDR_W-1:0] insad;
  } bundle_t;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_BUSY,
    S_FULL
  } state_t;

  state_t           state_q, state_d;
  bundle_t          main_q, main_d;
  bundle_t          skid_q, skid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  bundle_t          in_bundle;
  logic             accept;
  logic             issue;

  // Valid bits are decoded from the registered state, so in_ready never sees out_ready.
  assign in_ready  = (state_q != S_FULL);
  assign out_valid = (state_q != S_EMPTY);
  assign accept    = in_valid & in_ready;
  assign issue     = out_valid & out_ready;

  assign in_bundle = '{wb: WB1, mem: M1, ex: EX, a4: fIFIDa4, br1: fBR1, br2: fBR2,
                       se: fSE, ins1: fIns1, ins2: fIns2, jump: jump_in, insad: insad_in};

  // Next-state, entry movement and stall counting.
  always_comb begin
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    stall_cnt_d = stall_cnt_q;

    unique case (state_q)
      S_EMPTY: begin
        if (accept) begin
          main_d  = in_bundle;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (accept && issue) begin
          main_d = in_bundle;
        end else if (accept) begin
          skid_d  = in_bundle;
          state_d = S_FULL;
        end else if (issue) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (issue) begin
          main_d  = skid_q;
          state_d = S_BUSY;
        end
      end
      default: state_d = S_EMPTY;
    endcase

    // Flush overrides everything: drop held entries, keep data fields as they were.
    if (flush) begin
      state_d = S_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end

    if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State, entry and counter registers.
  always_ff @(posedge clkIDEX or negedge rstIDEX_n) begin
    if (!rstIDEX_n) begin
      state_q     <= S_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Output decode; bubbles force side-effecting control to zero.
  always_comb begin
    Wb1       = out_valid ? main_q.wb : '0;
    Mem1      = out_valid ? main_q.mem : '0;
    jump_out  = out_valid & main_q.jump;
    RegDst    = main_q.ex[0];
    ALUOp     = main_q.ex[ALUOP_W:1];
    ALUSrc    = main_q.ex[ALUOP_W+1];
    tAdd      = main_q.a4;
    tALU      = main_q.br1;
    tMux32    = main_q.br2;
    tACsl     = main_q.se;
    tMux5_1   = main_q.ins1;
    tMux5_2   = main_q.ins2;
    insad_out = main_q.insad;
    stall_cnt = stall_cnt_q;
  end

endmodule

// File: tb/tb_idex_skid_stage.sv
// Directed bench for idex_skid_stage: reset, streaming, back-pressure, EX decode,
// flush and stall-counter saturation (second instance with a 4-bit counter).
module tb_idex_skid_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, flush, out_ready, jump_in;
  logic [1:0]  WB1;
  logic [2:0]  M1;
  logic [4:0]  EX;
  logic [31:0] fIFIDa4, fBR1, fBR2, fSE;
  logic [4:0]  fIns1, fIns2;
  logic [25:0] insad_in;

  logic        in_ready, out_valid, RegDst, ALUSrc, jump_out;
  logic [1:0]  Wb1;
  logic [2:0]  Mem1, ALUOp;
  logic [31:0] tAdd, tALU, tMux32, tACsl;
  logic [4:0]  tMux5_1, tMux5_2;
  logic [25:0] insad_out;
  logic [15:0] stall_cnt;

  logic        s_in_ready, s_out_valid, s_RegDst, s_ALUSrc, s_jump_out;
  logic [1:0]  s_Wb1;
  logic [2:0]  s_Mem1, s_ALUOp;
  logic [31:0] s_tAdd, s_tALU, s_tMux32, s_tACsl;
  logic [4:0]  s_tMux5_1, s_tMux5_2;
  logic [25:0] s_insad_out;
  logic [3:0]  s_stall_cnt;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  idex_skid_stage dut (
    .clkIDEX(clk), .rstIDEX_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .WB1(WB1), .M1(M1), .EX(EX), .fIFIDa4(fIFIDa4), .fBR1(fBR1),
    .fBR2(fBR2), .fSE(fSE), .fIns1(fIns1), .fIns2(fIns2), .jump_in(jump_in),
    .insad_in(insad_in), .out_valid(out_valid), .out_ready(out_ready), .Wb1(Wb1),
    .Mem1(Mem1), .RegDst(RegDst), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .tAdd(tAdd),
    .tALU(tALU), .tMux32(tMux32), .tACsl(tACsl), .tMux5_1(tMux5_1),
    .tMux5_2(tMux5_2), .jump_out(jump_out), .insad_out(insad_out),
    .stall_cnt(stall_cnt)
  );

  idex_skid_stage #(.CNT_W(4)) dut_sat (
    .clkIDEX(clk), .rstIDEX_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .flush(flush), .WB1(WB1), .M1(M1), .EX(EX), .fIFIDa4(fIFIDa4), .fBR1(fBR1),
    .fBR2(fBR2), .fSE(fSE), .fIns1(fIns1), .fIns2(fIns2), .jump_in(jump_in),
    .insad_in(insad_in), .out_valid(s_out_valid), .out_ready(out_ready), .Wb1(s_Wb1),
    .Mem1(s_Mem1), .RegDst(s_RegDst), .ALUOp(s_ALUOp), .ALUSrc(s_ALUSrc), .tAdd(s_tAdd),
    .tALU(s_tALU), .tMux32(s_tMux32), .tACsl(s_tACsl), .tMux5_1(s_tMux5_1),
    .tMux5_2(s_tMux5_2), .jump_out(s_jump_out), .insad_out(s_insad_out),
    .stall_cnt(s_stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; jump_in = 1'b0;
    WB1 = '0; M1 = '0; EX = '0; fIFIDa4 = '0; fBR1 = '0; fBR2 = '0; fSE = '0;
    fIns1 = '0; fIns2 = '0; insad_in = '0;
  endtask

  initial begin
    // Reset with random inputs applied
    rst_n = 1'b0;
    in_valid = 1'b1; flush = 1'b0; out_ready = $urandom_range(0, 1) == 1;
    jump_in = 1'b1; WB1 = 2'b11; M1 = 3'($urandom); EX = 5'($urandom);
    fIFIDa4 = $urandom; fBR1 = $urandom; fBR2 = $urandom; fSE = $urandom;
    fIns1 = 5'($urandom); fIns2 = 5'($urandom); insad_in = 26'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_wb1", 64'(Wb1), 64'd0);
    check("rst_tadd", 64'(tAdd), 64'd0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    idle_inputs();
    #3;
    rst_n = 1'b1;
    tick();

    // First transfer: 1-cycle latency
    in_valid = 1'b1; fIFIDa4 = 32'h0000_0404; WB1 = 2'b10;
    tick();
    check("lat_out_valid", 64'(out_valid), 64'd1);
    check("lat_tadd", 64'(tAdd), 64'h404);
    check("lat_wb1", 64'(Wb1), 64'd2);
    in_valid = 1'b0;
    tick();
    check("lat_drained", 64'(out_valid), 64'd0);

    // Streaming at full rate
    do_reset();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; fBR1 = 32'(i);
      tick();
      check("stream_talu", 64'(tALU), 64'(i));
      check("stream_valid", 64'(out_valid), 64'd1);
      check("stream_in_ready", 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_empty", 64'(out_valid), 64'd0);
    check("stream_stall_cnt", 64'(stall_cnt), 64'd0);

    // Back-pressure: A held, B in skid, C waits
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; fBR1 = 32'hA;
    tick();
    check("bp_a_main", 64'(tALU), 64'hA);
    check("bp_a_in_ready", 64'(in_ready), 64'd1);
    fBR1 = 32'hB;
    tick();
    check("bp_hold_a", 64'(tALU), 64'hA);
    check("bp_full_in_ready", 64'(in_ready), 64'd0);
    check("bp_cnt1", 64'(stall_cnt), 64'd1);
    fBR1 = 32'hC;
    tick();
    check("bp_hold_a2", 64'(tALU), 64'hA);
    check("bp_full_in_ready2", 64'(in_ready), 64'd0);
    check("bp_cnt2", 64'(stall_cnt), 64'd2);
    out_ready = 1'b1;
    tick();
    check("bp_b_out", 64'(tALU), 64'hB);
    check("bp_in_ready_back", 64'(in_ready), 64'd1);
    tick();
    check("bp_c_out", 64'(tALU), 64'hC);
    check("bp_c_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    tick();
    check("bp_empty", 64'(out_valid), 64'd0);
    check("bp_cnt_final", 64'(stall_cnt), 64'd2);

    // EX decode
    do_reset();
    in_valid = 1'b1; EX = 5'b10111; M1 = 3'b101; jump_in = 1'b1; fIns1 = 5'd9;
    tick();
    check("ex_regdst", 64'(RegDst), 64'd1);
    check("ex_aluop", 64'(ALUOp), 64'd3);
    check("ex_alusrc", 64'(ALUSrc), 64'd1);
    check("ex_mem1", 64'(Mem1), 64'd5);
    check("ex_jump", 64'(jump_out), 64'd1);
    check("ex_ins1", 64'(tMux5_1), 64'd9);
    idle_inputs();
    tick();
    check("bubble_mem1", 64'(Mem1), 64'd0);
    check("bubble_data_hold", 64'(tMux5_1), 64'd9);

    // Flush in FULL with a simultaneous accept attempt
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; WB1 = 2'b11; M1 = 3'b111; jump_in = 1'b1; fBR1 = 32'h11;
    tick();
    fBR1 = 32'h22;
    tick();
    check("fl_full", 64'(in_ready), 64'd0);
    flush = 1'b1; fBR1 = 32'h33;
    tick();
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_wb1", 64'(Wb1), 64'd0);
    check("fl_mem1", 64'(Mem1), 64'd0);
    check("fl_jump", 64'(jump_out), 64'd0);
    check("fl_in_ready", 64'(in_ready), 64'd1);
    check("fl_cnt_kept", 64'(stall_cnt), 64'd2);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fl_no_ghost", 64'(out_valid), 64'd0);
    end

    // Stall counter saturation on the 4-bit instance
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; fBR1 = 32'h5;
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    check("sat_cnt15", 64'(s_stall_cnt), 64'd15);
    check("sat_wide_cnt20", 64'(stall_cnt), 64'd20);
    repeat (3) tick();
    check("sat_cnt_hold", 64'(s_stall_cnt), 64'd15);
    check("sat_wide_cnt23", 64'(stall_cnt), 64'd23);

    // Reset mid-transfer drops held entries
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_cnt", 64'(stall_cnt), 64'd0);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
